// File: rtl/func_table_search_mgr.sv
// func_table_search_mgr
// Holds a table of ascending function start addresses, filled by a
// sequential loader. A binary search returns the greatest entry that is
// less than or equal to a trace address, which identifies the function
// containing that address.
//
// Handshakes: a load is taken on a rising edge where load_valid and
// load_ready are both high, unless load_clear is also high with busy low,
// in which case the clear wins and the load is dropped. A search is taken
// on a rising edge where search_start is high and busy is low; find is
// sampled on that edge. done pulses for one cycle when the result outputs
// are valid, and those outputs stay unchanged until the next search
// completes.
module func_table_search_mgr #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_clear,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    output logic              load_ready,
    output logic [ADDR_W:0]   entry_count,
    input  logic              search_start,
    input  logic [DATA_W-1:0] find,
    output logic              busy,
    output logic              done,
    output logic              hit,
    output logic [ADDR_W-1:0] result_index,
    output logic [DATA_W-1:0] result_value
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        CMP  = 2'd2,
        FIN  = 2'd3
    } state_t;

    state_t state;
    state_t state_n;

    // Table storage: one write port (loader), one registered read port (search).
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata;

    // Search bounds are one bit wider than the index so hi can equal DEPTH.
    logic [ADDR_W:0]   lo;
    logic [ADDR_W:0]   hi;
    logic [ADDR_W:0]   mid;
    logic [ADDR_W:0]   mid_r;
    logic [ADDR_W+1:0] sum;
    logic [ADDR_W:0]   lo_n;
    logic [ADDR_W:0]   hi_n;
    logic              le;

    logic [DATA_W-1:0] find_r;
    logic              hit_r;
    logic [ADDR_W-1:0] idx_r;
    logic [DATA_W-1:0] val_r;

    logic load_acc;
    logic clear_acc;
    logic search_acc;

    assign clear_acc  = load_clear & ~busy;
    assign load_acc   = load_valid & load_ready & ~clear_acc;
    assign search_acc = (state == IDLE) & search_start;
    assign load_ready = ~busy & (entry_count != DEPTH_C);

    // Entry counter: clear has priority over an append in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            entry_count <= '0;
        end else if (clear_acc) begin
            entry_count <= '0;
        end else if (load_acc) begin
            entry_count <= entry_count + (ADDR_W + 1)'(1);
        end
    end

    // Table write port, fed by the loader at the next free slot.
    always_ff @(posedge clk) begin
        if (load_acc) begin
            mem[entry_count[ADDR_W-1:0]] <= load_data;
        end
    end

    // Midpoint of the current window; the sum is one bit wider so it cannot wrap.
    always_comb begin
        sum = {1'b0, lo} + {1'b0, hi};
        mid = (ADDR_W + 1)'(sum >> 1);
    end

    // Table read port: one-cycle latency, addressed by the midpoint during RD.
    always_ff @(posedge clk) begin
        rdata <= mem[mid[ADDR_W-1:0]];
    end

    // Narrow the window from the entry just read back.
    always_comb begin
        le   = (rdata <= find_r);
        lo_n = lo;
        hi_n = hi;
        if (le) begin
            lo_n = mid_r + (ADDR_W + 1)'(1);
        end else begin
            hi_n = mid_r;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic; an empty table goes straight to FIN.
    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (search_start) begin
                    state_n = (entry_count == '0) ? FIN : RD;
                end
            end
            RD:      state_n = CMP;
            CMP:     state_n = (lo_n < hi_n) ? RD : FIN;
            FIN:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Output decode: the engine is busy in every state except IDLE.
    always_comb begin
        busy = (state != IDLE);
    end

    // Search datapath and result registers; results only change on leaving FIN.
    always_ff @(posedge clk) begin
        if (reset) begin
            lo           <= '0;
            hi           <= '0;
            mid_r        <= '0;
            find_r       <= '0;
            hit_r        <= 1'b0;
            idx_r        <= '0;
            val_r        <= '0;
            done         <= 1'b0;
            hit          <= 1'b0;
            result_index <= '0;
            result_value <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (search_acc) begin
                        find_r <= find;
                        lo     <= '0;
                        hi     <= entry_count;
                        hit_r  <= 1'b0;
                        idx_r  <= '0;
                        val_r  <= '0;
                    end
                end
                RD: begin
                    mid_r <= mid;
                end
                CMP: begin
                    lo <= lo_n;
                    hi <= hi_n;
                    if (le) begin
                        hit_r <= 1'b1;
                        idx_r <= mid_r[ADDR_W-1:0];
                        val_r <= rdata;
                    end
                end
                FIN: begin
                    done         <= 1'b1;
                    hit          <= hit_r;
                    result_index <= idx_r;
                    result_value <= val_r;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_func_table_search_mgr.sv
// Bench for func_table_search_mgr with an 8-entry table (ADDR_W=3).
// The reference model keeps the table in a queue and finds the answer by a
// linear scan; latency comes from counting binary-search probes.
module tb_func_table_search_mgr;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 3;
    localparam int DEPTH  = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              load_clear;
    logic              load_valid;
    logic [DATA_W-1:0] load_data;
    logic              load_ready;
    logic [ADDR_W:0]   entry_count;
    logic              search_start;
    logic [DATA_W-1:0] find;
    logic              busy;
    logic              done;
    logic              hit;
    logic [ADDR_W-1:0] result_index;
    logic [DATA_W-1:0] result_value;

    int n_cmp = 0;
    int n_err = 0;

    logic [DATA_W-1:0] tbl[$];

    func_table_search_mgr #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .load_clear(load_clear), .load_valid(load_valid),
        .load_data(load_data), .load_ready(load_ready), .entry_count(entry_count),
        .search_start(search_start), .find(find), .busy(busy), .done(done),
        .hit(hit), .result_index(result_index), .result_value(result_value)
    );

    // Clock and reset
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic void ref_search(input logic [DATA_W-1:0] f, output logic h,
                                       output int ix, output logic [DATA_W-1:0] v,
                                       output int lat);
        int lo, hi, mid, iter;
        h = 1'b0; ix = 0; v = '0;
        foreach (tbl[i]) if (tbl[i] <= f) begin h = 1'b1; ix = i; v = tbl[i]; end
        lo = 0; hi = tbl.size(); iter = 0;
        while (lo < hi) begin
            iter++;
            mid = (lo + hi) / 2;
            if (tbl[mid] <= f) lo = mid + 1; else hi = mid;
        end
        lat = 2 * iter + 2;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; load_clear = 1'b0; load_valid = 1'b0; load_data = '0;
        search_start = 1'b0; find = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        tbl.delete();
    endtask

    task automatic load_entry(input logic [DATA_W-1:0] d);
        @(negedge clk);
        load_valid = 1'b1; load_data = d;
        @(negedge clk);
        load_valid = 1'b0;
    endtask

    // Starts a search and returns the cycle (1 = first cycle after the
    // accepting edge) in which done was seen, or -1 if it never came.
    task automatic drive_search(input logic [DATA_W-1:0] f, output int lat, output logic h,
                                output logic [ADDR_W-1:0] ix, output logic [DATA_W-1:0] v);
        lat = -1; h = 1'b0; ix = '0; v = '0;
        @(negedge clk);
        search_start = 1'b1; find = f;
        @(posedge clk);
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            search_start = 1'b0;
            if (done) begin
                lat = c; h = hit; ix = result_index; v = result_value;
                break;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int lat; logic h; logic [ADDR_W-1:0] ix; logic [DATA_W-1:0] v;
        do_reset();
        n_cmp++; if (entry_count !== 4'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", entry_count); end
        n_cmp++; if ({busy, done, hit} !== 3'b000) begin n_err++; $display("FAIL reset_flags: got busy/done/hit=%b want 000", {busy, done, hit}); end
        n_cmp++; if ({result_index, result_value} !== '0) begin n_err++; $display("FAIL reset_result: got idx=%0d val=%h want 0/0", result_index, result_value); end
        n_cmp++; if (load_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", load_ready); end
        drive_search(16'h1234, lat, h, ix, v);
        n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL empty_latency: got %0d want 2", lat); end
        n_cmp++; if ({h, ix, v} !== '0) begin n_err++; $display("FAIL empty_result: got hit=%b idx=%0d val=%h want 0/0/0", h, ix, v); end
    endtask

    task automatic test_directed();
        logic [DATA_W-1:0] finds [4] = '{16'h0350, 16'h0800, 16'h00FF, 16'hFFFF};
        logic              e_hit [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        int                e_idx [4] = '{2, 7, 0, 7};
        logic [DATA_W-1:0] e_val [4] = '{16'h0300, 16'h0800, 16'h0000, 16'h0800};
        int lat, mlat, mix; logic h, mh; logic [ADDR_W-1:0] ix; logic [DATA_W-1:0] v, mv;
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            load_entry(DATA_W'(i * 16'h0100));
            tbl.push_back(DATA_W'(i * 16'h0100));
        end
        n_cmp++; if (entry_count !== 4'd8) begin n_err++; $display("FAIL dir_count: got %0d want 8", entry_count); end
        for (int k = 0; k < 4; k++) begin
            ref_search(finds[k], mh, mix, mv, mlat);
            drive_search(finds[k], lat, h, ix, v);
            n_cmp++; if (lat < 1 || lat > 10 || lat != mlat) begin n_err++; $display("FAIL dir_latency[%0d]: got %0d want %0d (<=10)", k, lat, mlat); end
            n_cmp++; if (h !== e_hit[k] || h !== mh) begin n_err++; $display("FAIL dir_hit[%0d]: got %b want %b", k, h, e_hit[k]); end
            n_cmp++; if (ix !== ADDR_W'(e_idx[k]) || v !== e_val[k]) begin n_err++; $display("FAIL dir_result[%0d]: got idx=%0d val=%h want idx=%0d val=%h", k, ix, v, e_idx[k], e_val[k]); end
        end
        repeat (3) @(negedge clk);
        n_cmp++; if (result_value !== 16'h0800 || hit !== 1'b1) begin n_err++; $display("FAIL hold_result: got hit=%b val=%h want 1/0800", hit, result_value); end
    endtask

    task automatic test_full();
        int lat; logic h; logic [ADDR_W-1:0] ix; logic [DATA_W-1:0] v;
        n_cmp++; if (load_ready !== 1'b0) begin n_err++; $display("FAIL full_ready: got %b want 0", load_ready); end
        load_entry(16'h0900);
        n_cmp++; if (entry_count !== 4'd8) begin n_err++; $display("FAIL full_count: got %0d want 8", entry_count); end
        drive_search(16'hFFFF, lat, h, ix, v);
        n_cmp++; if (v !== 16'h0800 || ix !== 3'd7) begin n_err++; $display("FAIL full_search: got idx=%0d val=%h want 7/0800", ix, v); end
    endtask

    task automatic test_simultaneous();
        int lat, mlat, mix; logic mh; logic [DATA_W-1:0] mv; logic h; logic [ADDR_W-1:0] ix; logic [DATA_W-1:0] v;
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            load_entry(DATA_W'(i * 16'h0100));
            tbl.push_back(DATA_W'(i * 16'h0100));
        end
        ref_search(16'hFFFF, mh, mix, mv, mlat);
        tbl.push_back(16'h0400);
        @(negedge clk);
        search_start = 1'b1; find = 16'hFFFF; load_valid = 1'b1; load_data = 16'h0400;
        @(posedge clk);
        lat = -1; h = 1'b0; ix = '0; v = '0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            search_start = 1'b0; load_valid = 1'b0;
            load_clear = (c == 1);
            if (c == 1) begin
                n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL simul_busy: got %b want 1", busy); end
            end
            if (done) begin lat = c; h = hit; ix = result_index; v = result_value; break; end
        end
        load_clear = 1'b0;
        n_cmp++; if (lat != mlat || h !== 1'b1 || ix !== 3'd2 || v !== 16'h0300) begin n_err++; $display("FAIL simul_result: got lat=%0d hit=%b idx=%0d val=%h want %0d/1/2/0300", lat, h, ix, v, mlat); end
        n_cmp++; if (entry_count !== 4'd4) begin n_err++; $display("FAIL simul_count: got %0d want 4", entry_count); end
    endtask

    task automatic test_clear();
        int lat; logic h; logic [ADDR_W-1:0] ix; logic [DATA_W-1:0] v;
        @(negedge clk);
        load_clear = 1'b1; load_valid = 1'b1; load_data = 16'h0010;
        @(negedge clk);
        load_clear = 1'b0; load_valid = 1'b0;
        tbl.delete();
        n_cmp++; if (entry_count !== 4'd0) begin n_err++; $display("FAIL clear_count: got %0d want 0", entry_count); end
        drive_search(16'hFFFF, lat, h, ix, v);
        n_cmp++; if (lat !== 2 || h !== 1'b0) begin n_err++; $display("FAIL clear_search: got lat=%0d hit=%b want 2/0", lat, h); end
    endtask

    task automatic test_reset_mid();
        int ndone; int lat; logic h; logic [ADDR_W-1:0] ix; logic [DATA_W-1:0] v;
        do_reset();
        for (int i = 1; i <= 8; i++) load_entry(DATA_W'(i * 16'h0100));
        @(negedge clk);
        search_start = 1'b1; find = 16'h0450;
        @(posedge clk);
        ndone = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            search_start = 1'b0;
            reset = (c == 3);
            if (done) ndone++;
        end
        n_cmp++; if (ndone !== 0) begin n_err++; $display("FAIL rst_mid_done: got %0d pulses want 0", ndone); end
        n_cmp++; if (busy !== 1'b0 || entry_count !== 4'd0) begin n_err++; $display("FAIL rst_mid_state: got busy=%b count=%0d want 0/0", busy, entry_count); end
        n_cmp++; if ({hit, result_index, result_value} !== '0) begin n_err++; $display("FAIL rst_mid_result: got hit=%b idx=%0d val=%h want 0", hit, result_index, result_value); end
        drive_search(16'h0450, lat, h, ix, v);
        n_cmp++; if (lat !== 2 || h !== 1'b0) begin n_err++; $display("FAIL rst_mid_search: got lat=%0d hit=%b want 2/0", lat, h); end
    endtask

    task automatic test_back_to_back();
        int ndone, mlat, mix; logic mh; logic [DATA_W-1:0] mv, first;
        logic h; logic [ADDR_W-1:0] ix; logic [DATA_W-1:0] v;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            load_entry(DATA_W'(16'h1000 + i * 16'h0800));
            tbl.push_back(DATA_W'(16'h1000 + i * 16'h0800));
        end
        first = DATA_W'($urandom_range(16'h1000, 16'h5000));
        ref_search(first, mh, mix, mv, mlat);
        @(negedge clk);
        search_start = 1'b1; find = first;
        @(posedge clk);
        ndone = 0; h = 1'b0; ix = '0; v = '0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            search_start = (c < mlat - 1);
            find = DATA_W'($urandom);
            if (done) begin ndone++; h = hit; ix = result_index; v = result_value; end
        end
        search_start = 1'b0;
        n_cmp++; if (ndone !== 1) begin n_err++; $display("FAIL b2b_pulses: got %0d want 1", ndone); end
        n_cmp++; if (h !== mh || ix !== ADDR_W'(mix) || v !== mv) begin n_err++; $display("FAIL b2b_result: got %b/%0d/%h want %b/%0d/%h", h, ix, v, mh, mix, mv); end
    endtask

    task automatic test_random();
        int n, lat, mlat, mix, mode; logic mh; logic [DATA_W-1:0] mv, f, val;
        logic h; logic [ADDR_W-1:0] ix; logic [DATA_W-1:0] v;
        for (int r = 0; r < 12; r++) begin
            @(negedge clk); load_clear = 1'b1;
            @(negedge clk); load_clear = 1'b0;
            tbl.delete();
            n = $urandom_range(0, DEPTH);
            val = DATA_W'($urandom_range(0, 16'h1000));
            for (int i = 0; i < n; i++) begin
                load_entry(val);
                tbl.push_back(val);
                val = val + DATA_W'($urandom_range(1, 16'h1800));
            end
            n_cmp++; if (entry_count !== (ADDR_W+1)'(n)) begin n_err++; $display("FAIL rnd_count[%0d]: got %0d want %0d", r, entry_count, n); end
            for (int s = 0; s < 6; s++) begin
                mode = $urandom_range(0, 2);
                if (n > 0 && mode == 0) f = tbl[$urandom_range(0, n - 1)];
                else if (n > 0 && mode == 1) f = tbl[$urandom_range(0, n - 1)] - 16'd1;
                else f = DATA_W'($urandom);
                ref_search(f, mh, mix, mv, mlat);
                drive_search(f, lat, h, ix, v);
                n_cmp++; if (lat != mlat || h !== mh || ix !== ADDR_W'(mix) || v !== mv) begin
                    n_err++;
                    $display("FAIL rnd_search[%0d.%0d] find=%h: got lat=%0d %b/%0d/%h want lat=%0d %b/%0d/%h", r, s, f, lat, h, ix, v, mlat, mh, mix, mv);
                end
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        reset = 1'b1; load_clear = 1'b0; load_valid = 1'b0; load_data = '0;
        search_start = 1'b0; find = '0;
        test_reset();
        test_directed();
        test_full();
        test_simultaneous();
        test_clear();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
